// File: rtl/mul_if.sv
// Handshake bundle between an issuing stage and the shift-add multiplier.
// The master issues operands and acknowledges results.
// The slave (the multiplier) reports ready/busy/valid and the product.
interface mul_if #(
    parameter int word_width = 16
);
    logic                      start;
    logic [word_width-1:0]     A;
    logic [word_width-1:0]     B;
    logic                      ack;
    logic                      ready;
    logic                      busy;
    logic                      valid;
    logic [2*word_width-1:0]   R;

    modport master (
        output start, A, B, ack,
        input  ready, busy, valid, R
    );

    modport slave (
        input  start, A, B, ack,
        output ready, busy, valid, R
    );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier.
// One shared carry-lookahead adder is reused once per iteration.
// The partial product P shifts right by one bit each cycle.
// A start/ready + valid/ack handshake lets the issuing stage stall on the unit.

// Carry-lookahead adder built from cascade_size-bit lookahead groups.
// Group carries chain from one group to the next.
module fast_adder #(
    parameter int width        = 16,
    parameter int cascade_size = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             c_in,
    output logic [width-1:0] sum,
    output logic             c_out
);
    logic [width-1:0] gen;
    logic [width-1:0] prop;
    logic [width:0]   carry;
    logic             term;
    logic             chain;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Expanded lookahead carries inside each group, seeded by the group's carry-in
    always_comb begin
        carry    = '0;
        term     = 1'b0;
        chain    = 1'b1;
        carry[0] = c_in;
        for (int grp = 0; grp < width / cascade_size; grp++) begin
            for (int i = 0; i < cascade_size; i++) begin
                chain = 1'b1;
                term  = 1'b0;
                for (int j = i; j >= 0; j--) begin
                    term  = term | (chain & gen[grp*cascade_size + j]);
                    chain = chain & prop[grp*cascade_size + j];
                end
                carry[grp*cascade_size + i + 1] = term | (chain & carry[grp*cascade_size]);
            end
        end
    end

    assign sum   = prop ^ carry[width-1:0];
    assign c_out = carry[width];
endmodule

module mul_sequencer #(
    parameter int word_width   = 16,
    parameter int cascade_size = 4
) (
    input  logic  clk,
    input  logic  reset,
    mul_if.slave  bus
);
    localparam int step_w = $clog2(word_width) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [2*word_width-1:0] p_q;
    logic [word_width-1:0]   m_q;
    logic [step_w-1:0]       step_q;
    logic                    busy_q;
    logic                    valid_q;
    logic [word_width-1:0]   addend;
    logic [word_width-1:0]   sum;
    logic                    c_out;
    logic                    last_step;
    logic                    ready;
    logic                    accept;
    logic                    calc_en;

    // Add the multiplicand into the upper half only when the current multiplier bit is set
    assign addend    = p_q[0] ? m_q : '0;
    assign last_step = (step_q == step_w'(word_width - 1));

    fast_adder #(
        .width        (word_width),
        .cascade_size (cascade_size)
    ) u_adder (
        .a     (p_q[2*word_width-1:word_width]),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a DONE result acked together with start chains straight into CALC
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (bus.ack)   state_d = bus.start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake decode: operands are accepted whenever start meets ready
    always_comb begin
        ready   = (state_q == IDLE) || ((state_q == DONE) && bus.ack);
        accept  = bus.start && ready;
        calc_en = (state_q == CALC);
    end

    // Partial product, multiplicand and iteration count
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q    <= '0;
            m_q    <= '0;
            step_q <= '0;
        end else if (accept) begin
            p_q    <= {{word_width{1'b0}}, bus.B};
            m_q    <= bus.A;
            step_q <= '0;
        end else if (calc_en) begin
            p_q    <= {c_out, sum, p_q[word_width-1:1]};
            step_q <= step_q + 1'b1;
        end
    end

    // Registered status flags track the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            busy_q  <= (state_d == CALC);
            valid_q <= (state_d == DONE);
        end
    end

    assign bus.ready = ready;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.R     = p_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and random checks for the shift-add multiplier sequencer.
module tb_mul_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mul_if #(.word_width(16)) bus ();

    mul_sequencer #(.word_width(16), .cascade_size(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge: 16 busy cycles, then the result
    task automatic wait_calc(input logic [31:0] exp, input string tag, input bit inject);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_busy"}, {62'd0, bus.busy, bus.valid}, 64'd2);
            if (inject && i == 5) begin
                bus.start = 1'b1;
                bus.A     = 16'hFFFF;
                bus.B     = 16'hFFFF;
            end
            tick();
            bus.start = 1'b0;
        end
        check({tag, "_done"}, {62'd0, bus.busy, bus.valid}, 64'd1);
        check({tag, "_R"}, 64'(bus.R), 64'(exp));
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic release_result(input string tag);
        bus.ack = 1'b1;
        #1;
        check({tag, "_ready_on_ack"}, 64'(bus.ready), 64'd1);
        tick();
        bus.ack = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.valid), 64'd0);
        check({tag, "_ready_idle"}, 64'(bus.ready), 64'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          cnt;
        bit          saw_valid;

        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        tick();
        tick();
        check("reset_flags", {61'd0, bus.busy, bus.valid, bus.ready}, 64'd1);
        check("reset_R", 64'(bus.R), 64'd0);
        reset = 1'b0;
        tick();

        // Basic product, held result while ack stays low
        launch(16'd3, 16'd5);
        wait_calc(32'h0000000F, "basic", 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold", {31'd0, bus.valid, bus.R}, {31'd0, 1'b1, 32'h0000000F});
        end

        // Back-to-back accept on the ack edge; start pulse mid-CALC is ignored
        bus.ack   = 1'b1;
        bus.start = 1'b1;
        bus.A     = 16'd7;
        bus.B     = 16'd9;
        #1;
        check("b2b_ready", 64'(bus.ready), 64'd1);
        tick();
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        wait_calc(32'h0000003F, "b2b", 1'b1);
        release_result("b2b");

        // Boundary operands
        launch(16'hFFFF, 16'hFFFF);
        wait_calc(32'hFFFE0001, "max", 1'b0);
        release_result("max");
        launch(16'h8000, 16'h0002);
        wait_calc(32'h00010000, "msb", 1'b0);
        release_result("msb");
        launch(16'h0000, 16'h1234);
        wait_calc(32'h00000000, "zero", 1'b0);
        release_result("zero");
        launch(16'h1234, 16'h0001);
        wait_calc(32'h00001234, "ident", 1'b0);
        release_result("ident");

        // Reset in the eighth CALC cycle abandons the operation
        launch(16'h00FF, 16'h0100);
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_flags", {61'd0, bus.busy, bus.valid, bus.ready}, 64'd1);
        check("midrst_R", 64'(bus.R), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valid) saw_valid = 1'b1;
        end
        check("midrst_no_valid", 64'(saw_valid), 64'd0);
        launch(16'h00FF, 16'h0100);
        wait_calc(32'h0000FF00, "after_rst", 1'b0);
        release_result("after_rst");

        // Random regression with random ack delay
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            launch(ra, rb);
            cnt = 0;
            while (!bus.valid && cnt < 40) begin
                tick();
                cnt++;
            end
            check("rand_latency", 64'(cnt), 64'd16);
            check("rand_R", 64'(bus.R), 64'(32'(ra) * 32'(rb)));
            if (!bus.valid) break;
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
